// File: rtl/axi_adc_jesd204_pnstat.sv
// PN test result tracker for one JESD204 ADC channel.
// Consumes the PN monitor's out-of-sync / error flags, tracks lock with an
// acquisition timeout, and keeps clearable saturating error and lock-loss
// counters, sticky flags and the time taken to reach first lock.
module axi_adc_jesd204_pnstat #(
    parameter int COUNT_WIDTH     = 32,
    parameter int OOS_COUNT_WIDTH = 16,
    parameter int LOCK_TIMEOUT    = 4096
) (
    input  logic                       adc_clk,
    input  logic                       adc_rstn,
    input  logic                       adc_pn_oos,
    input  logic                       adc_pn_err,
    input  logic                       adc_pn_enable,
    input  logic                       adc_pn_clear,
    output logic [1:0]                 adc_pn_state,
    output logic [COUNT_WIDTH-1:0]     adc_pn_err_count,
    output logic [OOS_COUNT_WIDTH-1:0] adc_pn_oos_count,
    output logic [COUNT_WIDTH-1:0]     adc_pn_lock_time,
    output logic                       adc_pn_lock_valid,
    output logic                       adc_pn_err_sticky,
    output logic                       adc_pn_oos_sticky,
    output logic                       adc_pn_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_FAIL    = 2'd3
    } pn_state_t;

    localparam logic [COUNT_WIDTH-1:0]     CNT_ZERO   = {COUNT_WIDTH{1'b0}};
    localparam logic [COUNT_WIDTH-1:0]     CNT_ONE    = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0]     CNT_MAX    = {COUNT_WIDTH{1'b1}};
    localparam logic [COUNT_WIDTH-1:0]     TIMER_LAST = COUNT_WIDTH'(LOCK_TIMEOUT - 1);
    localparam logic [OOS_COUNT_WIDTH-1:0] OOS_ZERO   = {OOS_COUNT_WIDTH{1'b0}};
    localparam logic [OOS_COUNT_WIDTH-1:0] OOS_ONE    = OOS_COUNT_WIDTH'(1);
    localparam logic [OOS_COUNT_WIDTH-1:0] OOS_MAX    = {OOS_COUNT_WIDTH{1'b1}};

    pn_state_t                  state_r,      state_s;
    logic [COUNT_WIDTH-1:0]     timer_r,      timer_s;
    logic [COUNT_WIDTH-1:0]     err_count_r,  err_count_s;
    logic [OOS_COUNT_WIDTH-1:0] oos_count_r,  oos_count_s;
    logic [COUNT_WIDTH-1:0]     lock_time_r,  lock_time_s;
    logic                       lock_valid_r, lock_valid_s;
    logic                       err_sticky_r, err_sticky_s;
    logic                       oos_sticky_r, oos_sticky_s;
    logic                       timeout_r;

    // Next-state and result update; clear outranks disable, which outranks per-state activity.
    always_comb begin
        state_s      = state_r;
        timer_s      = timer_r;
        err_count_s  = err_count_r;
        oos_count_s  = oos_count_r;
        lock_time_s  = lock_time_r;
        lock_valid_s = lock_valid_r;
        err_sticky_s = err_sticky_r;
        oos_sticky_s = oos_sticky_r;

        if (adc_pn_clear) begin
            err_count_s  = CNT_ZERO;
            oos_count_s  = OOS_ZERO;
            lock_time_s  = CNT_ZERO;
            lock_valid_s = 1'b0;
            err_sticky_s = 1'b0;
            oos_sticky_s = 1'b0;
            timer_s      = CNT_ZERO;
            if (adc_pn_enable) begin
                state_s = ST_ACQUIRE;
            end else begin
                state_s = ST_IDLE;
            end
        end else if (!adc_pn_enable) begin
            // Disabling only stops the test; results stay readable.
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s      = ST_ACQUIRE;
                    timer_s      = CNT_ZERO;
                    lock_time_s  = CNT_ZERO;
                    lock_valid_s = 1'b0;
                end
                ST_ACQUIRE: begin
                    if (!adc_pn_oos) begin
                        state_s = ST_LOCKED;
                        if (!lock_valid_r) begin
                            lock_time_s  = timer_r;
                            lock_valid_s = 1'b1;
                        end else begin
                            lock_time_s  = lock_time_r;
                        end
                    end else if (timer_r == TIMER_LAST) begin
                        state_s = ST_FAIL;
                    end else begin
                        timer_s = timer_r + CNT_ONE;
                    end
                end
                ST_LOCKED: begin
                    if (adc_pn_oos) begin
                        state_s      = ST_ACQUIRE;
                        timer_s      = CNT_ZERO;
                        oos_sticky_s = 1'b1;
                        if (oos_count_r != OOS_MAX) begin
                            oos_count_s = oos_count_r + OOS_ONE;
                        end else begin
                            oos_count_s = oos_count_r;
                        end
                    end else if (adc_pn_err) begin
                        err_sticky_s = 1'b1;
                        if (err_count_r != CNT_MAX) begin
                            err_count_s = err_count_r + CNT_ONE;
                        end else begin
                            err_count_s = err_count_r;
                        end
                    end else begin
                        state_s = ST_LOCKED;
                    end
                end
                ST_FAIL: begin
                    // Terminal until disabled or cleared.
                    state_s = ST_FAIL;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State and result registers.
    always_ff @(posedge adc_clk or negedge adc_rstn) begin
        if (!adc_rstn) begin
            state_r      <= ST_IDLE;
            timer_r      <= CNT_ZERO;
            err_count_r  <= CNT_ZERO;
            oos_count_r  <= OOS_ZERO;
            lock_time_r  <= CNT_ZERO;
            lock_valid_r <= 1'b0;
            err_sticky_r <= 1'b0;
            oos_sticky_r <= 1'b0;
            timeout_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            timer_r      <= timer_s;
            err_count_r  <= err_count_s;
            oos_count_r  <= oos_count_s;
            lock_time_r  <= lock_time_s;
            lock_valid_r <= lock_valid_s;
            err_sticky_r <= err_sticky_s;
            oos_sticky_r <= oos_sticky_s;
            timeout_r    <= (state_s == ST_FAIL);
        end
    end

    assign adc_pn_state      = state_r;
    assign adc_pn_err_count  = err_count_r;
    assign adc_pn_oos_count  = oos_count_r;
    assign adc_pn_lock_time  = lock_time_r;
    assign adc_pn_lock_valid = lock_valid_r;
    assign adc_pn_err_sticky = err_sticky_r;
    assign adc_pn_oos_sticky = oos_sticky_r;
    assign adc_pn_timeout    = timeout_r;

endmodule

// File: tb/tb_axi_adc_jesd204_pnstat.sv
// Bench for axi_adc_jesd204_pnstat: a wide instance (timeout 16) and a narrow
// instance (4-bit error counter, 2-bit lock-loss counter, timeout 8) share the
// same stimulus and are each compared against a behavioural model every cycle.
module tb_axi_adc_jesd204_pnstat;

    localparam int A_CW = 32, A_OW = 16, A_TMO = 16;
    localparam int B_CW = 4,  B_OW = 2,  B_TMO = 8;

    logic adc_clk = 1'b0;
    logic adc_rstn = 1'b0;
    logic adc_pn_oos = 1'b0, adc_pn_err = 1'b0, adc_pn_enable = 1'b0, adc_pn_clear = 1'b0;

    logic [1:0]      a_state,  b_state;
    logic [A_CW-1:0] a_errc,   a_lt;
    logic [A_OW-1:0] a_oosc;
    logic [B_CW-1:0] b_errc,   b_lt;
    logic [B_OW-1:0] b_oosc;
    logic a_lv, a_es, a_os, a_tmo, b_lv, b_es, b_os, b_tmo;

    int checks = 0;
    int failures = 0;

    axi_adc_jesd204_pnstat #(.COUNT_WIDTH(A_CW), .OOS_COUNT_WIDTH(A_OW), .LOCK_TIMEOUT(A_TMO)) dut_a (
        .adc_clk(adc_clk), .adc_rstn(adc_rstn), .adc_pn_oos(adc_pn_oos), .adc_pn_err(adc_pn_err),
        .adc_pn_enable(adc_pn_enable), .adc_pn_clear(adc_pn_clear), .adc_pn_state(a_state),
        .adc_pn_err_count(a_errc), .adc_pn_oos_count(a_oosc), .adc_pn_lock_time(a_lt),
        .adc_pn_lock_valid(a_lv), .adc_pn_err_sticky(a_es), .adc_pn_oos_sticky(a_os),
        .adc_pn_timeout(a_tmo));

    axi_adc_jesd204_pnstat #(.COUNT_WIDTH(B_CW), .OOS_COUNT_WIDTH(B_OW), .LOCK_TIMEOUT(B_TMO)) dut_b (
        .adc_clk(adc_clk), .adc_rstn(adc_rstn), .adc_pn_oos(adc_pn_oos), .adc_pn_err(adc_pn_err),
        .adc_pn_enable(adc_pn_enable), .adc_pn_clear(adc_pn_clear), .adc_pn_state(b_state),
        .adc_pn_err_count(b_errc), .adc_pn_oos_count(b_oosc), .adc_pn_lock_time(b_lt),
        .adc_pn_lock_valid(b_lv), .adc_pn_err_sticky(b_es), .adc_pn_oos_sticky(b_os),
        .adc_pn_timeout(b_tmo));

    always #5 adc_clk = ~adc_clk;

    // Behavioural view of one channel: 0 idle, 1 acquiring, 2 locked, 3 failed.
    typedef struct {
        int     st;
        longint timer;
        longint errc;
        longint oosc;
        longint lt;
        bit     lv;
        bit     es;
        bit     os;
    } mdl_t;

    mdl_t m_a, m_b;

    function automatic mdl_t mdl_reset();
        mdl_t z;
        z.st = 0; z.timer = 0; z.errc = 0; z.oosc = 0; z.lt = 0;
        z.lv = 1'b0; z.es = 1'b0; z.os = 1'b0;
        return z;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, bit en, bit clr, bit oos, bit err,
                                      longint tmo, longint cmax, longint omax);
        mdl_t n = m;
        if (clr) begin
            n = mdl_reset();
            n.st = en ? 1 : 0;
            return n;
        end
        if (!en) begin
            n.st = 0;
            return n;
        end
        case (m.st)
            0: begin n.st = 1; n.timer = 0; n.lt = 0; n.lv = 1'b0; end
            1: begin
                if (!oos) begin
                    n.st = 2;
                    if (!m.lv) begin n.lt = m.timer; n.lv = 1'b1; end
                end else if (m.timer + 1 == tmo) begin
                    n.st = 3;
                end else begin
                    n.timer = m.timer + 1;
                end
            end
            2: begin
                if (oos) begin
                    n.st = 1; n.timer = 0; n.os = 1'b1;
                    if (m.oosc < omax) n.oosc = m.oosc + 1;
                end else if (err) begin
                    n.es = 1'b1;
                    if (m.errc < cmax) n.errc = m.errc + 1;
                end
            end
            default: ;
        endcase
        return n;
    endfunction

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check_eq("a_state",  longint'(a_state), longint'(m_a.st));
        check_eq("a_errc",   longint'(a_errc),  m_a.errc);
        check_eq("a_oosc",   longint'(a_oosc),  m_a.oosc);
        check_eq("a_lt",     longint'(a_lt),    m_a.lt);
        check_eq("a_lv",     longint'(a_lv),    longint'(m_a.lv));
        check_eq("a_es",     longint'(a_es),    longint'(m_a.es));
        check_eq("a_os",     longint'(a_os),    longint'(m_a.os));
        check_eq("a_tmo",    longint'(a_tmo),   longint'(m_a.st == 3));
        check_eq("b_state",  longint'(b_state), longint'(m_b.st));
        check_eq("b_errc",   longint'(b_errc),  m_b.errc);
        check_eq("b_oosc",   longint'(b_oosc),  m_b.oosc);
        check_eq("b_lt",     longint'(b_lt),    m_b.lt);
        check_eq("b_lv",     longint'(b_lv),    longint'(m_b.lv));
        check_eq("b_es",     longint'(b_es),    longint'(m_b.es));
        check_eq("b_os",     longint'(b_os),    longint'(m_b.os));
        check_eq("b_tmo",    longint'(b_tmo),   longint'(m_b.st == 3));
    endtask

    // Apply one cycle of inputs, advance the models at the edge, check 1 ns later.
    task automatic step(input bit en, input bit clr, input bit oos, input bit err);
        adc_pn_enable = en; adc_pn_clear = clr; adc_pn_oos = oos; adc_pn_err = err;
        @(posedge adc_clk);
        m_a = mdl_step(m_a, en, clr, oos, err, A_TMO, (64'd1 << A_CW) - 1, (64'd1 << A_OW) - 1);
        m_b = mdl_step(m_b, en, clr, oos, err, B_TMO, (64'd1 << B_CW) - 1, (64'd1 << B_OW) - 1);
        #1;
        check_all();
    endtask

    initial begin
        int mode, len;
        bit en, clr, oos, err;
        m_a = mdl_reset();
        m_b = mdl_reset();

        // Reset state
        repeat (3) @(posedge adc_clk);
        #1;
        check_all();
        check_eq("rst_state", longint'(a_state), 0);
        #2 adc_rstn = 1'b1;

        // Immediate lock from the start
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("t1_acq", longint'(a_state), 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("t1_lock", longint'(a_state), 2);
        check_eq("t1_lt", longint'(a_lt), 0);
        check_eq("t1_lv", longint'(a_lv), 1);

        // Lock after 10 out-of-sync ACQUIRE cycles
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (10) step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("t2_lt", longint'(a_lt), 10);
        check_eq("t2_state", longint'(a_state), 2);
        check_eq("t2_tmo", longint'(a_tmo), 0);

        // Timeout after exactly 16 ACQUIRE cycles, then disable
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (15) step(1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("t2_not_yet", longint'(a_state), 1);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("t2_fail", longint'(a_state), 3);
        check_eq("t2_tmo1", longint'(a_tmo), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("t2_idle", longint'(a_state), 0);

        // Errors, a lock loss, relock keeps first lock time
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("t3_errc", longint'(a_errc), 5);
        check_eq("t3_oosc", longint'(a_oosc), 1);
        check_eq("t3_es", longint'(a_es), 1);
        check_eq("t3_os", longint'(a_os), 1);
        check_eq("t3_lt", longint'(a_lt), 3);

        // Narrow error counter saturates at 15
        repeat (20) step(1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("t4_sat", longint'(b_errc), 15);
        check_eq("t4_wide", longint'(a_errc), 25);

        // Clear wins over a same-cycle error, then relock at time 0
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check_eq("t5_errc", longint'(a_errc), 0);
        check_eq("t5_es", longint'(a_es), 0);
        check_eq("t5_state", longint'(a_state), 1);
        check_eq("t5_lv", longint'(a_lv), 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("t5_relock", longint'(a_state), 2);
        check_eq("t5_lt", longint'(a_lt), 0);
        check_eq("t5_lv1", longint'(a_lv), 1);

        // Randomized segments
        for (int s = 0; s < 80; s++) begin
            mode = $urandom_range(0, 4);
            len  = $urandom_range(5, 40);
            for (int c = 0; c < len; c++) begin
                en  = ($urandom_range(0, 99) < ((mode == 3) ? 60 : 98));
                clr = ($urandom_range(0, 99) < ((mode == 4) ? 10 : 1));
                oos = ($urandom_range(0, 99) < ((mode == 1) ? 95 : ((mode == 0) ? 20 : 5)));
                err = ($urandom_range(0, 99) < ((mode == 2) ? 70 : 15));
                step(en, clr, oos, err);
            end
        end

        // Asynchronous reset between edges
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);
        #3 adc_rstn = 1'b0;
        #1;
        m_a = mdl_reset();
        m_b = mdl_reset();
        check_all();
        check_eq("arst_errc", longint'(a_errc), 0);
        #2 adc_rstn = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_adc_jesd204_pnstat.md
Name: axi_adc_jesd204_pnstat

Overview:
Downstream companion of the per-channel PN monitor in the JESD204 ADC core. It consumes the monitor's pn_oos/pn_err flags and runs a lock-tracking state machine with an acquisition timeout. It also accumulates saturating error and lock-loss counters, sticky flags and a first-lock time. These give software a stable, clearable PN test result per channel.

Parameters:
COUNT_WIDTH, 32, width of error counter, lock timer and lock-time result
OOS_COUNT_WIDTH, 16, width of lock-loss counter
LOCK_TIMEOUT, 4096, number of ACQUIRE cycles allowed before declaring FAIL (>=2, < 2**COUNT_WIDTH)

Ports:
adc_clk  input  1  core clock, all logic on rising edge
adc_rstn  input  1  asynchronous active-low reset
adc_pn_oos  input  1  PN out-of-sync from monitor
adc_pn_err  input  1  PN error from monitor
adc_pn_enable  input  1  test enable level
adc_pn_clear  input  1  single-cycle clear request
adc_pn_state  output  2  0=IDLE 1=ACQUIRE 2=LOCKED 3=FAIL
adc_pn_err_count  output  COUNT_WIDTH  errored cycles while LOCKED, saturating
adc_pn_oos_count  output  OOS_COUNT_WIDTH  LOCKED->ACQUIRE transitions, saturating
adc_pn_lock_time  output  COUNT_WIDTH  ACQUIRE cycles before first lock
adc_pn_lock_valid  output  1  lock_time captured
adc_pn_err_sticky  output  1  any error counted since clear
adc_pn_oos_sticky  output  1  any lock loss since clear
adc_pn_timeout  output  1  high iff state==FAIL

Behaviour:
- Clock and reset: single clock adc_clk; reset adc_rstn is asynchronous, active-low.
- Reset: state=IDLE; all counters, lock_time, timer and all flags 0.
- Outputs are registered. Every input sampled at edge N is reflected at the outputs after edge N, with 1-cycle latency.
- Timer: internal, counts cycles spent in ACQUIRE. It is 0 in the first ACQUIRE cycle and reloads to 0 on every entry to ACQUIRE.
- IDLE:
  - enable=1 -> ACQUIRE.
  - On that transition, clear lock_time and lock_valid.
  - Counters and stickies hold.
- ACQUIRE, oos=0 -> LOCKED. If lock_valid=0, load lock_time<=timer and set lock_valid=1.
- ACQUIRE, oos=1:
  - timer==LOCK_TIMEOUT-1 -> FAIL.
  - Otherwise timer+1.
  - Exactly LOCK_TIMEOUT oos cycles produce FAIL.
- LOCKED:
  - oos=1 -> ACQUIRE, oos_count+1 (saturating), oos_sticky=1. err is ignored in that cycle.
  - oos=0 and err=1 -> err_count+1 (saturating at all-ones), err_sticky=1.
- FAIL: terminal. Counters frozen. Exits only via enable=0 or clear.
- enable=0 in any state -> IDLE next cycle. Counters, stickies and lock_time hold. A mid-operation disable does not clear results.
- err/oos are ignored in IDLE and FAIL. err is ignored in ACQUIRE.
- clear=1:
  - Zeroes err_count, oos_count, lock_time, lock_valid and both stickies.
  - Next state is ACQUIRE with timer=0 if enable=1, else IDLE.
  - Clear has priority over any same-cycle increment, capture or transition.
- Saturation: a counter at its maximum stays at its maximum. No wrap.
- Reset asserted mid-operation: everything returns to reset values immediately, regardless of clock.

Test Plan:
- Reset, enable=1 with oos=0 from the start -> state 1 at cycle 1, state 2 at cycle 2; lock_time=0, lock_valid=1, all counts 0.
- LOCK_TIMEOUT=16, enable=1, oos=1 for 10 cycles then 0 -> lock_time=10, state=LOCKED, timeout=0. Repeat with oos held at 1 -> FAIL after exactly 16 ACQUIRE cycles, timeout=1; then enable=0 -> IDLE next cycle.
- LOCKED, err=1 for 5 cycles, then oos=1 and err=1 for 1 cycle, then oos=0 -> err_count=5, oos_count=1, both stickies=1. lock_time keeps its first value after relock.
- COUNT_WIDTH=4, err=1 for 20 locked cycles -> err_count stops at 15.
- clear pulse in the same cycle as err=1 while LOCKED -> err_count=0, err_sticky=0, state=ACQUIRE, lock_valid=0. With oos=0 the block relocks next cycle and captures lock_time=0.
- adc_rstn low asynchronously mid-count (between edges) -> all outputs 0 and state=IDLE before the next edge.
